// File: rtl/rope_pkg.sv
// Shared types and helpers for the rope array engine.
// Rope states, fixed-point format, colours, anchor placement.
package rope_pkg;

  typedef enum logic [1:0] {
    MOVE_POS,
    MOVE_NEG,
    HOLD,
    RELEASE
  } rope_state_t;

  localparam int FRAC_BITS = 6;

  localparam logic [7:0] ROPE_COLOR = 8'hB4;
  localparam logic [7:0] HELD_COLOR = 8'hFC;

  function automatic int anchor_x(
    input int i,
    input int left_ropes,
    input int left_x0,
    input int right_x0,
    input int spacing
  );
    if (i < left_ropes) return left_x0 + i * spacing;
    return right_x0 + (i - left_ropes) * spacing;
  endfunction

endpackage

// File: rtl/rope_channel.sv
// One rope: direction FSM, Q.6 offset, grab/release timer,
// and the registered pixel hit test.
module rope_channel
  import rope_pkg::*;
#(
  parameter int ANCHOR_X       = 100,
  parameter int TOP_Y          = 80,
  parameter int ROPE_W         = 4,
  parameter int ROPE_LEN       = 128,
  parameter int SWING          = 16,
  parameter int SPEED          = 20,
  parameter int RELEASE_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_of_frame,
  input  logic [10:0]        pixel_x,
  input  logic [10:0]        pixel_y,
  input  logic               dir_toggle,
  input  logic               collision,
  output logic               dr_o,
  output logic               dr_held_o,
  output logic               held_o,
  output logic signed [31:0] speed_o
);

  localparam logic signed [15:0] BOUND = 16'(SWING << FRAC_BITS);
  localparam logic signed [15:0] SPD   = 16'(SPEED);
  localparam logic signed [31:0] SPD_X = {{16{SPD[15]}}, SPD};
  localparam logic [15:0] REL_LAST     = 16'(RELEASE_FRAMES - 1);
  localparam logic signed [11:0] AX    = 12'(ANCHOR_X);
  localparam logic signed [11:0] TY    = 12'(TOP_Y);
  localparam logic signed [11:0] RW    = 12'(ROPE_W);
  localparam logic signed [11:0] RL    = 12'(ROPE_LEN);

  rope_state_t        state_q, state_d;
  rope_state_t        dir_q, dir_d;
  rope_state_t        mv_dir;
  logic signed [15:0] off_q, off_d;
  logic signed [15:0] sum;
  logic               tog_q, tog_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [31:0] spd_q, spd_d;
  logic               dr_q, dr_d;
  logic               hdr_q, hdr_d;

  logic signed [11:0] pix_off;
  logic signed [11:0] x_lo, x_hi, y_hi;
  logic signed [11:0] px_s, py_s;

  assign held_o = (state_q == HOLD) || (state_q == RELEASE);

  // Next state: motion, toggle latch, grab and timed release.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    off_d   = off_q;
    tog_d   = tog_q;
    cnt_d   = cnt_q;
    mv_dir  = state_q;
    sum     = off_q;
    unique case (state_q)
      MOVE_POS, MOVE_NEG: begin
        if (collision) begin
          state_d = HOLD;
          dir_d   = state_q;
          tog_d   = 1'b0;
        end else begin
          tog_d = tog_q | dir_toggle;
          if (start_of_frame) begin
            if (tog_d)
              mv_dir = (state_q == MOVE_POS) ? MOVE_NEG : MOVE_POS;
            sum = (mv_dir == MOVE_POS) ? off_q + SPD : off_q - SPD;
            if (sum > BOUND) begin
              sum    = BOUND;
              mv_dir = MOVE_NEG;
            end else if (sum < -BOUND) begin
              sum    = -BOUND;
              mv_dir = MOVE_POS;
            end
            off_d   = sum;
            state_d = mv_dir;
            tog_d   = 1'b0;
          end
        end
      end
      HOLD: begin
        tog_d = 1'b0;
        if (!collision) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        tog_d = 1'b0;
        if (collision) begin
          state_d = HOLD;
        end else if (start_of_frame) begin
          if (cnt_q == REL_LAST) begin
            state_d = dir_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = MOVE_POS;
    endcase
  end

  // Signed speed follows the next state so it lands with it.
  always_comb begin
    spd_d = '0;
    unique case (state_d)
      MOVE_POS: spd_d = SPD_X;
      MOVE_NEG: spd_d = -SPD_X;
      default:  spd_d = '0;
    endcase
  end

  // Pixel hit test in 12-bit signed space so a negative left edge
  // cannot wrap into a large positive column.
  always_comb begin
    pix_off = 12'(off_q >>> FRAC_BITS);
    x_lo    = AX + pix_off;
    x_hi    = x_lo + RW;
    y_hi    = TY + RL;
    px_s    = $signed({1'b0, pixel_x});
    py_s    = $signed({1'b0, pixel_y});
    dr_d    = (px_s >= x_lo) && (px_s < x_hi) &&
              (py_s >= TY) && (py_s < y_hi);
    hdr_d   = held_o;
  end

  // State, offset and draw-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MOVE_POS;
      dir_q   <= MOVE_POS;
      off_q   <= '0;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
      spd_q   <= SPD_X;
      dr_q    <= 1'b0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      off_q   <= off_d;
      tog_q   <= tog_d;
      cnt_q   <= cnt_d;
      spd_q   <= spd_d;
      dr_q    <= dr_d;
      hdr_q   <= hdr_d;
    end
  end

  assign dr_o      = dr_q;
  assign dr_held_o = hdr_q;
  assign speed_o   = spd_q;

endmodule

// File: rtl/rope_array_ctrl.sv
// N-rope engine: generated rope channels plus the
// lowest-index priority mux for the object mixer.
module rope_array_ctrl
  import rope_pkg::*;
#(
  parameter int NUM_ROPES      = 6,
  parameter int LEFT_ROPES     = 3,
  parameter int LEFT_X0        = 100,
  parameter int RIGHT_X0       = 400,
  parameter int LEFT_Y         = 80,
  parameter int RIGHT_Y        = 100,
  parameter int SPACING        = 40,
  parameter int ROPE_W         = 4,
  parameter int ROPE_LEN       = 128,
  parameter int SWING          = 16,
  parameter int SPEED_STEP     = 20,
  parameter int RELEASE_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [10:0]                pixelX,
  input  logic [10:0]                pixelY,
  input  logic [NUM_ROPES-1:0]       dirToggle,
  input  logic [NUM_ROPES-1:0]       monkeyCollision,
  output logic [NUM_ROPES-1:0]       ropeDR,
  output logic                       anyRopeDR,
  output logic [3:0]                 ropeIdx,
  output logic [7:0]                 ropeRGB,
  output logic [NUM_ROPES-1:0][31:0] SIGNED_SPEEDS,
  output logic [NUM_ROPES-1:0]       ropeHeld
);

  logic [NUM_ROPES-1:0] dr_held;

  for (genvar i = 0; i < NUM_ROPES; i++) begin : g_rope
    localparam int AX = anchor_x(i, LEFT_ROPES, LEFT_X0,
                                 RIGHT_X0, SPACING);
    localparam int TY = (i < LEFT_ROPES) ? LEFT_Y : RIGHT_Y;

    rope_channel #(
      .ANCHOR_X      (AX),
      .TOP_Y         (TY),
      .ROPE_W        (ROPE_W),
      .ROPE_LEN      (ROPE_LEN),
      .SWING         (SWING),
      .SPEED         ((i + 1) * SPEED_STEP),
      .RELEASE_FRAMES(RELEASE_FRAMES)
    ) u_ch (
      .clk           (clk),
      .rst_n         (resetN),
      .start_of_frame(startOfFrame),
      .pixel_x       (pixelX),
      .pixel_y       (pixelY),
      .dir_toggle    (dirToggle[i]),
      .collision     (monkeyCollision[i]),
      .dr_o          (ropeDR[i]),
      .dr_held_o     (dr_held[i]),
      .held_o        (ropeHeld[i]),
      .speed_o       (SIGNED_SPEEDS[i])
    );
  end

  // Lowest index wins; colour comes from the registered draw stage.
  always_comb begin
    anyRopeDR = |ropeDR;
    ropeIdx   = '0;
    ropeRGB   = '0;
    for (int i = NUM_ROPES - 1; i >= 0; i--) begin
      if (ropeDR[i]) begin
        ropeIdx = 4'(i);
        ropeRGB = dr_held[i] ? HELD_COLOR : ROPE_COLOR;
      end
    end
  end

endmodule

// File: doc/rope_array_ctrl.md
Name: rope_array_ctrl

Overview:
- Parametrised N-rope engine for the Donkey Kong Jr playfield; replaces fixed left/right rope groups with one generated array.
- Per rope: horizontal sliding motion, a direction FSM, a grab/hold state driven by monkey collision, and a timed release.
- Sits between the VGA pixel counters and the object mux; emits per-rope and merged drawing requests, RGB, and per-rope signed speeds for the monkey-motion block.

Parameters:
- NUM_ROPES, 6, total ropes (1..16)
- LEFT_ROPES, 3, ropes 0..LEFT_ROPES-1 form the left group; the rest form the right group
- LEFT_X0, 100, anchor X of rope 0
- RIGHT_X0, 400, anchor X of first right rope
- LEFT_Y, 80, top Y of left group
- RIGHT_Y, 100, top Y of right group
- SPACING, 40, X distance between ropes in a group
- ROPE_W, 4, rope width in pixels
- ROPE_LEN, 128, rope height in pixels
- SWING, 16, max |offset| in pixels
- SPEED_STEP, 20, rope i speed = (i+1)*SPEED_STEP in Q.6 px/frame
- RELEASE_FRAMES, 8, frames held after monkeyCollision drops

Ports:
- clk, input, 1, system clock
- resetN, input, 1, async active-low reset
- startOfFrame, input, 1, one-cycle pulse per frame
- pixelX, input, 11, current VGA X
- pixelY, input, 11, current VGA Y
- dirToggle, input, NUM_ROPES, per-rope direction-flip pulse
- monkeyCollision, input, NUM_ROPES, level: monkey touching rope i
- ropeDR, output, NUM_ROPES, per-rope drawing request
- anyRopeDR, output, 1, OR of ropeDR
- ropeIdx, output, 4, lowest index with ropeDR set (0 if none)
- ropeRGB, output, 8, colour of ropeIdx rope
- SIGNED_SPEEDS, output, NUM_ROPES x 32, signed velocity per rope, Q.6 px/frame
- ropeHeld, output, NUM_ROPES, rope i in HOLD or RELEASE

Behaviour:
- One clock (clk); resetN asynchronous, active-low. All state clears immediately on resetN=0.
- Reset values:
  - offset = 0, state = MOVE_POS, toggle latch = 0, release counter = 0.
  - ropeDR, anyRopeDR, ropeIdx, ropeRGB, ropeHeld = 0.
  - SIGNED_SPEEDS[i] = +(i+1)*SPEED_STEP.
- Per-rope state, 16-bit signed offset in Q.6; pixel offset = offset>>>6.
- FSM states:
  - MOVE_POS, MOVE_NEG: the only states that move the rope. On startOfFrame, offset ±= speed. If the result crosses ±SWING<<6, clamp to the bound and flip direction.
  - HOLD: entered from either MOVE state on any cycle monkeyCollision[i]=1. Remembers prior direction. Offset frozen.
  - RELEASE: entered when monkeyCollision[i]=0. Counts RELEASE_FRAMES startOfFrame pulses, then returns to the remembered direction. Re-entry to HOLD if monkeyCollision rises again.
- dirToggle[i]:
  - Pulse sets a sticky latch; the latch is consumed at the next startOfFrame in a MOVE state by flipping direction before the add.
  - Latch is cleared and ignored while in HOLD or RELEASE.
  - Toggle and bound-clamp in the same frame: a single flip only. The toggle flips before the add; the clamp then flips only if the bound is still crossed.
- SIGNED_SPEEDS[i]: +speed in MOVE_POS, -speed in MOVE_NEG, 0 in HOLD/RELEASE. Updated with the state register (same cycle as state).
- Anchor X = group base + (i - group start)*SPACING. Top Y = group Y.
- ropeDR[i] registered, 1-cycle latency from pixelX/pixelY, asserted when both hold:
  - x in [anchor+pix_offset, anchor+pix_offset+ROPE_W)
  - y in [top, top+ROPE_LEN)
- ropeRGB colour:
  - ROPE_COLOR in MOVE states.
  - HELD_COLOR in HOLD/RELEASE.
  - Driven from the same registered stage as ropeDR; 0 when anyRopeDR=0.
- Priority: lowest index wins for ropeIdx/ropeRGB when ropes overlap.
- Width rules:
  - Offset arithmetic is 16-bit signed.
  - Pixel compare is 12-bit signed, to avoid wrap when anchor+offset < 0.
  - Speeds sign-extend to 32.

Decomposition:
- rope_pkg:
  - rope_state_t enum {MOVE_POS, MOVE_NEG, HOLD, RELEASE}
  - FRAC_BITS=6
  - ROPE_COLOR, HELD_COLOR
  - function anchor_x(i)
- Sub-module rope_channel holds one rope's FSM, offset, release counter, and pixel compare. rope_array_ctrl generates NUM_ROPES instances plus the priority mux and OR.

Test Plan:
- Reset, then 1 frame, NUM_ROPES=6 -> rope 0 offset 20 (0.31 px), SIGNED_SPEEDS[0]=+20, SIGNED_SPEEDS[5]=+120.
- Rope 5 (speed 120) runs 9 frames -> clamps at +1024 (16 px), then MOVE_NEG, SIGNED_SPEEDS[5]=-120.
- dirToggle[1] pulse mid-frame plus bound reached the same frame -> exactly one flip; next speed sign correct.
- monkeyCollision[2]=1 for 5 frames, then 0 -> offset frozen, speed 0, ropeHeld[2]=1 for 5+8 frames, then prior direction resumes.
- Pixel (100,80) at reset -> ropeDR[0]=1, ropeIdx=0, ropeRGB=ROPE_COLOR one cycle later; (100,208) -> ropeDR[0]=0.
- resetN dropped mid-HOLD -> all outputs at reset values asynchronously; motion restarts MOVE_POS after release.
